imem_loader: RTL and testbench
==============================

# imem_loader

Host-side program loader that writes 16-bit instruction/data words into the CPU's synchronous memory, the write end of the single-port memory interface the core reads from. Accepts a framed byte stream (length header, big-endian words, optional checksum) over a valid/ready handshake, typically from a UART receiver. Assembles each word and issues one single-cycle write per word. Holds the pipelined core in reset while a load is in progress.

## Interface
Parameters:
- `BASE_ADDR`, default 16'h0000: address written by the first word.
- `DEPTH`, default 256: maximum word count accepted in one load.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERROR.
- `byte_in`, in, 8: stream byte.
- `byte_valid`, in, 1: `byte_in` is valid.
- `byte_ready`, out, 1: loader accepts a byte. A transfer occurs on a rising edge with valid && ready.
- `mem_address`, out, 16: write address.
- `mem_data`, out, 16: write data.
- `mem_wren`, out, 1: write strobe, one cycle per word.
- `cpu_hold`, out, 1: drives the core's reset while loading.
- `done`, out, 1: load completed successfully (level).
- `error`, out, 1: load aborted (level).
- `words_loaded`, out, 16: number of words written in the current or last load.

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + `start`:
  - Go to LEN_HI.
  - Clear `done`, `error`, `words_loaded` and the checksum.
  - Set `cpu_hold`.
- LEN_HI accept: latch N[15:8], go to LEN_LO.
- LEN_LO accept: latch N[7:0], then branch:
  - N > DEPTH: go to ERROR.
  - N == 0: go to CHECK, or to DONE if checksum is compiled out.
  - Otherwise: go to DATA_HI.
- DATA_HI accept: hold the high byte, go to DATA_LO.
- DATA_LO accept:
  - Next cycle: `mem_data` = {hi, lo}, `mem_address` = BASE_ADDR + `words_loaded`, `mem_wren` = 1.
  - Increment `words_loaded`.
  - If this was word N, go to CHECK (or DONE); else go to DATA_HI.
- CHECK accept: compare the byte with the running checksum. Equal goes to DONE, else ERROR.
- Checksum: 8-bit sum mod 256 of every accepted byte, length bytes included, check byte excluded.
- DONE: `done` = 1 and `cpu_hold` = 0.
- ERROR: `error` = 1 and `cpu_hold` stays 1 until the next `start`. Words already written are not rolled back.
- `byte_ready` = 1 in LEN_HI..CHECK, 0 in IDLE/DONE/ERROR. Bytes presented while not ready are not consumed.
- `start` while in LEN_HI..CHECK is ignored.
- Address arithmetic is 16-bit and wraps modulo 2^16.

## Timing
- Reset values:
  - state IDLE, `byte_ready` 0.
  - `mem_address` = BASE_ADDR, `mem_data` 0, `mem_wren` 0.
  - `cpu_hold` 0, `done` 0, `error` 0, `words_loaded` 0.
- All outputs are registered.
- `cpu_hold` rises the cycle after `start`.
- Throughput is one byte per cycle while `byte_valid` stays high. Gaps in `byte_valid` stall without side effects.
- `mem_wren` is high exactly one cycle, the cycle after the DATA_LO transfer. `mem_address`/`mem_data` are valid in that cycle and hold afterwards.
- `done`/`error` assert the cycle after the final transfer (CHECK, last DATA_LO, or LEN_LO). In that same cycle `cpu_hold` falls on success.
- The last `mem_wren` and `done` may assert in the same cycle.
- Reset mid-load:
  - Outputs return to reset values immediately.
  - No write is issued after reset asserts.
  - The partially loaded memory content is undefined.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The CHECK state exists.
  - The frame ends with one checksum byte.
  - A mismatch goes to ERROR.
- Not defined:
  - No CHECK state and no checksum logic.
  - The frame ends after the last data byte; N == 0 goes directly to DONE.
  - `error` asserts only for N > DEPTH.

## Test plan
- Checksum on, BASE_ADDR 0: stream 00 03 12 34 AB CD 00 FF C0 back-to-back.
  - Writes 1234@0, ABCD@1, 00FF@2.
  - `done` = 1, `words_loaded` = 3, `cpu_hold` falls.
- Same stream with check byte C1: all three writes occur, `error` = 1, `cpu_hold` stays 1, `done` = 0.
- Stream 00 00 00: no `mem_wren`, `done` = 1.
  - With the macro undefined, 00 00 alone gives `done`.
- DEPTH 256, stream 01 01: `error` the cycle after the second byte, `byte_ready` 0, no writes.
- `byte_valid` toggling every other cycle on the 3-word stream gives identical writes. A `start` pulse mid-stream is ignored.
- Assert `reset` after the second data word:
  - All outputs return to reset values and no third write occurs.
  - A new `start` with the full stream completes normally.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream and writes big-endian 16-bit words into the
// core's instruction memory, holding the core in reset for the whole load.
// Frame: N[15:8], N[7:0], N words (hi byte first), then one checksum byte when
// IMEM_LOADER_CHECKSUM_EN is defined (8-bit sum of every preceding frame byte).
module imem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data,
  output logic        mem_wren,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StCheck,
`endif
    StDone,
    StError
  } state_e;

  state_e state_q, state_d;

  logic [15:0] len_q, len_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] words_loaded_q, words_loaded_d;
  logic [15:0] mem_address_q, mem_address_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic        mem_wren_q, mem_wren_d;
  logic        byte_ready_q, byte_ready_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        xfer;
  logic [15:0] len_full;
  logic        last_word;

  // byte_ready_q always mirrors "state_q is a loading state", so this is the handshake.
  assign xfer      = byte_valid & byte_ready_q;
  assign len_full  = {len_q[15:8], byte_in};
  assign last_word = (words_loaded_q + 16'd1) == len_q;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      len_q          <= 16'd0;
      hi_q           <= 8'd0;
      words_loaded_q <= 16'd0;
      mem_address_q  <= BASE_ADDR;
      mem_data_q     <= 16'd0;
      mem_wren_q     <= 1'b0;
      byte_ready_q   <= 1'b0;
      cpu_hold_q     <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q         <= 8'd0;
`endif
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      hi_q           <= hi_d;
      words_loaded_q <= words_loaded_d;
      mem_address_q  <= mem_address_d;
      mem_data_q     <= mem_data_d;
      mem_wren_q     <= mem_wren_d;
      byte_ready_q   <= byte_ready_d;
      cpu_hold_q     <= cpu_hold_d;
      done_q         <= done_d;
      error_q        <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

  // Next state and datapath: frame parsing, word assembly and the write strobe.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    hi_d           = hi_q;
    words_loaded_d = words_loaded_q;
    mem_address_d  = mem_address_q;
    mem_data_d     = mem_data_q;
    mem_wren_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d         = csum_q;
`endif

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d        = StLenHi;
          words_loaded_d = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d         = 8'd0;
`endif
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_d[15:8] = byte_in;
          state_d     = StLenLo;
        end
      end
      StLenLo: begin
        if (xfer) begin
          len_d[7:0] = byte_in;
          if ({16'd0, len_full} > DEPTH) begin
            state_d = StError;
          end else if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (xfer) begin
          hi_d    = byte_in;
          state_d = StDataLo;
        end
      end
      StDataLo: begin
        if (xfer) begin
          mem_data_d     = {hi_q, byte_in};
          mem_address_d  = BASE_ADDR + words_loaded_q;
          mem_wren_d     = 1'b1;
          words_loaded_d = words_loaded_q + 16'd1;
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StDataHi;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (xfer) begin
          state_d = (byte_in == csum_q) ? StDone : StError;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Every accepted frame byte except the check byte itself feeds the sum.
    if (xfer && (state_q != StCheck)) begin
      csum_d = csum_q + byte_in;
    end
`endif
  end

  // Registered status outputs, decoded from the next state so they settle with it.
  always_comb begin
    byte_ready_d = !(state_d inside {StIdle, StDone, StError});
    cpu_hold_d   = !(state_d inside {StIdle, StDone});
    done_d       = (state_d == StDone);
    error_d      = (state_d == StError);
  end

  assign byte_ready   = byte_ready_q;
  assign mem_address  = mem_address_q;
  assign mem_data     = mem_data_q;
  assign mem_wren     = mem_wren_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Expected writes are queued as data bytes are driven
// and popped by a monitor whenever mem_wren is seen. Base address sits just below 2^16 so
// multi-word loads exercise address wrap.
module tb_imem_loader;

  localparam logic [15:0] Base  = 16'hFFFE;
  localparam int unsigned Depth = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader #(
    .BASE_ADDR(Base),
    .DEPTH    (Depth)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  int          n_cmp = 0;
  int          n_err = 0;
  wr_t         sb[$];
  logic [15:0] frame_words[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_wren === 1'b1) begin
      check_eq("wr_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        check_eq("wr_addr", 32'(mem_address), 32'(e.addr));
        check_eq("wr_data", 32'(mem_data), 32'(e.data));
      end
    end
  end

  task automatic check_reset_state();
    check_eq("rst_ready", 32'(byte_ready), 32'd0);
    check_eq("rst_addr", 32'(mem_address), 32'(Base));
    check_eq("rst_data", 32'(mem_data), 32'd0);
    check_eq("rst_wren", 32'(mem_wren), 32'd0);
    check_eq("rst_hold", 32'(cpu_hold), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_words", 32'(words_loaded), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge following the transfer (plus one idle
  // cycle when gap is set).
  task automatic send_byte(input logic [7:0] b, input bit gap, input bit pulse_start);
    int n;
    n          = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    if (pulse_start) start = 1'b1;
    while (byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (n >= 20) check_eq("ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    start = 1'b0;
    if (gap) begin
      byte_valid = 1'b0;
      byte_in    = 8'hEE;
      @(negedge clk);
    end
  endtask

  // Starts a load and streams header N, the words in frame_words and optionally a check
  // byte (good or corrupted). start_at names a byte index during which start is pulsed.
  task automatic send_frame(input logic [15:0] n, input bit gap, input int start_at,
                            input bit with_ck, input bit bad_ck);
    logic [7:0] bq[$];
    logic [7:0] sum;
    bq.push_back(n[15:8]);
    bq.push_back(n[7:0]);
    foreach (frame_words[i]) begin
      bq.push_back(frame_words[i][15:8]);
      bq.push_back(frame_words[i][7:0]);
    end
    sum = 8'd0;
    foreach (bq[i]) sum += bq[i];
    if (CkEn && with_ck) bq.push_back(bad_ck ? sum + 8'd1 : sum);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_hold", 32'(cpu_hold), 32'd1);
    check_eq("start_ready", 32'(byte_ready), 32'd1);
    check_eq("start_done_clr", 32'(done), 32'd0);
    check_eq("start_err_clr", 32'(error), 32'd0);
    check_eq("start_words_clr", 32'(words_loaded), 32'd0);

    for (int i = 0; i < bq.size(); i++) begin
      if (i >= 3 && (i % 2) == 1 && i < 2 + 2 * frame_words.size()) begin
        sb.push_back({Base + 16'((i - 3) / 2), frame_words[(i - 3) / 2]});
      end
      send_byte(bq[i], gap, i == start_at);
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_done(input logic [15:0] n_words);
    check_eq("done", 32'(done), 32'd1);
    check_eq("done_error", 32'(error), 32'd0);
    check_eq("done_hold", 32'(cpu_hold), 32'd0);
    check_eq("done_ready", 32'(byte_ready), 32'd0);
    check_eq("done_words", 32'(words_loaded), 32'(n_words));
    @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    @(negedge clk);

    // Three words, back to back.
    frame_words = '{16'h1234, 16'hABCD, 16'h00FF};
    send_frame(16'd3, 1'b0, -1, 1'b1, 1'b0);
    check_done(16'd3);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Corrupted check byte: writes still land, load ends in error with the core held.
    send_frame(16'd3, 1'b0, -1, 1'b1, 1'b1);
    check_eq("badck_error", 32'(error), 32'd1);
    check_eq("badck_done", 32'(done), 32'd0);
    check_eq("badck_hold", 32'(cpu_hold), 32'd1);
    check_eq("badck_words", 32'(words_loaded), 32'd3);
    @(negedge clk);
    check_eq("badck_sb", 32'(sb.size()), 32'd0);
`endif

    // Zero-length frame.
    frame_words = {};
    send_frame(16'd0, 1'b0, -1, 1'b1, 1'b0);
    check_done(16'd0);

    // Length above DEPTH: error right after the second byte, nothing written.
    send_frame(16'h0101, 1'b0, -1, 1'b0, 1'b0);
    check_eq("ovf_error", 32'(error), 32'd1);
    check_eq("ovf_done", 32'(done), 32'd0);
    check_eq("ovf_ready", 32'(byte_ready), 32'd0);
    check_eq("ovf_hold", 32'(cpu_hold), 32'd1);
    check_eq("ovf_words", 32'(words_loaded), 32'd0);
    // Bytes offered while not ready must not be taken.
    byte_valid = 1'b1;
    byte_in    = 8'h5A;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check_eq("ovf_still_error", 32'(error), 32'd1);
    check_eq("ovf_still_ready", 32'(byte_ready), 32'd0);

    // Gappy valid with a stray start pulse mid-stream.
    frame_words = '{16'h1234, 16'hABCD, 16'h00FF};
    send_frame(16'd3, 1'b1, 4, 1'b1, 1'b0);
    check_done(16'd3);

    // Exactly DEPTH words; addresses wrap past 0xFFFF.
    frame_words = {};
    for (int i = 0; i < Depth; i++) frame_words.push_back(16'(i * 16'h0103) ^ 16'h5A00);
    send_frame(16'(Depth), 1'b0, -1, 1'b1, 1'b0);
    check_done(16'(Depth));

    // Reset after the second of three words.
    frame_words = '{16'h1234, 16'hABCD};
    send_frame(16'd3, 1'b0, -1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("mid_sb", 32'(sb.size()), 32'd0);
    check_eq("mid_words", 32'(words_loaded), 32'd2);
    check_eq("mid_hold", 32'(cpu_hold), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_state();
    byte_valid = 1'b1;
    byte_in    = 8'h00;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    reset      = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("post_rst_words", 32'(words_loaded), 32'd0);
    check_eq("post_rst_ready", 32'(byte_ready), 32'd0);

    frame_words = '{16'h1234, 16'hABCD, 16'h00FF};
    send_frame(16'd3, 1'b0, -1, 1'b1, 1'b0);
    check_done(16'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
